// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC control path: FSM states, opcode values,
// addressing-mode constant and default field widths.
package sisc_pkg;

   localparam int SISC_OP_W     = 4;
   localparam int SISC_MM_W     = 4;
   localparam int SISC_STAT_W   = 4;
   localparam int SISC_ALU_OP_W = 2;

   localparam int OP_NOOP = 0;
   localparam int OP_LOD  = 1;
   localparam int OP_STR  = 2;
   localparam int OP_SWP  = 3;
   localparam int OP_BRA  = 4;
   localparam int OP_BRR  = 5;
   localparam int OP_BNE  = 6;
   localparam int OP_BNR  = 7;
   localparam int OP_ALU  = 8;
   localparam int OP_HLT  = 15;

   localparam int AM_IMM = 8;

   // Non-ALU instructions park the ALU field here: bit 1 set means "not an ALU op".
   localparam logic [1:0] ALU_OP_DEFAULT = 2'b10;

   // START0 is encoded as zero so a zero-initialised power-up lands there.
   typedef enum logic [3:0] {
      ST_START0    = 4'd0,
      ST_START1    = 4'd1,
      ST_FETCH     = 4'd2,
      ST_DECODE    = 4'd3,
      ST_EXECUTE   = 4'd4,
      ST_MEM       = 4'd5,
      ST_WRITEBACK = 4'd6,
      ST_WB2       = 4'd7,
      ST_HALT      = 4'd8
   } state_e;

endpackage

// File: rtl/sisc_ctrl_fsm_if.sv
// Control bundle between the SISC controller (master) and the datapath (slave):
// decoded IR fields and memory ready in, register/ALU/PC/memory controls out.
interface sisc_ctrl_fsm_if
   import sisc_pkg::*;
#(
   parameter int OP_W     = SISC_OP_W,
   parameter int MM_W     = SISC_MM_W,
   parameter int STAT_W   = SISC_STAT_W,
   parameter int ALU_OP_W = SISC_ALU_OP_W
) ();

   logic [OP_W-1:0]     opcode;
   logic [MM_W-1:0]     mm;
   logic [STAT_W-1:0]   stat;
   logic                mem_rdy;

   logic                rf_we;
   logic [ALU_OP_W-1:0] alu_op;
   logic                wb_sel;
   logic                ir_load;
   logic                pc_write;
   logic                pc_sel;
   logic                br_sel;
   logic                dm_we;
   logic                swp_sel;
   logic                halted;
   logic                fault;

   modport master (
      input  opcode, mm, stat, mem_rdy,
      output rf_we, alu_op, wb_sel, ir_load, pc_write, pc_sel, br_sel,
             dm_we, swp_sel, halted, fault
   );

   modport slave (
      output opcode, mm, stat, mem_rdy,
      input  rf_we, alu_op, wb_sel, ir_load, pc_write, pc_sel, br_sel,
             dm_we, swp_sel, halted, fault
   );

endinterface

// File: rtl/sisc_br_cond.sv
// Branch condition: BRA/BRR branch when any masked status flag is set,
// BNE/BNR branch when none is; every other opcode never branches.
module sisc_br_cond
   import sisc_pkg::*;
#(
   parameter int OP_W   = SISC_OP_W,
   parameter int MM_W   = SISC_MM_W,
   parameter int STAT_W = SISC_STAT_W
) (
   input  logic [OP_W-1:0]   opcode,
   input  logic [MM_W-1:0]   mm,
   input  logic [STAT_W-1:0] stat,
   output logic              taken
);

   logic hit;
   logic br_on_set;
   logic br_on_clear;

   // mm is never wider than stat, so zero-extending it keeps the mask exact.
   assign hit         = |(stat & STAT_W'(mm));
   assign br_on_set   = (opcode == OP_W'(OP_BRA)) || (opcode == OP_W'(OP_BRR));
   assign br_on_clear = (opcode == OP_W'(OP_BNE)) || (opcode == OP_W'(OP_BNR));
   assign taken       = (br_on_set && hit) || (br_on_clear && !hit);

endmodule

// File: rtl/sisc_ctrl_fsm.sv
// Multi-cycle SISC controller: fetch/decode/execute/mem/writeback sequencing,
// memory-ready wait with timeout fault, and a sticky halt left only by reset.
module sisc_ctrl_fsm
   import sisc_pkg::*;
#(
   parameter int OP_W        = SISC_OP_W,
   parameter int MM_W        = SISC_MM_W,
   parameter int STAT_W      = SISC_STAT_W,
   parameter int ALU_OP_W    = SISC_ALU_OP_W,
   parameter int TO_W        = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst_f,
   sisc_ctrl_fsm_if.master bus
);

   state_e              state_q, state_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic                halted_q, halted_d;
   logic                fault_q, fault_d;

   logic [OP_W-1:0]     opcode;
   logic [MM_W-1:0]     mm;
   logic                br_taken;
   logic                is_alu, is_imm, is_lod, is_str, is_swp, is_mem, is_rel, is_hlt;
   logic [ALU_OP_W-1:0] alu_op_instr;

   logic                rf_we, wb_sel, ir_load, pc_write, pc_sel, br_sel, dm_we, swp_sel;
   logic [ALU_OP_W-1:0] alu_op;

   assign opcode = bus.opcode;
   assign mm     = bus.mm;

   assign is_alu = (opcode == OP_W'(OP_ALU));
   assign is_imm = (mm == MM_W'(AM_IMM));
   assign is_lod = (opcode == OP_W'(OP_LOD));
   assign is_str = (opcode == OP_W'(OP_STR));
   assign is_swp = (opcode == OP_W'(OP_SWP));
   assign is_mem = is_lod || is_str || is_swp;
   assign is_rel = (opcode == OP_W'(OP_BRR)) || (opcode == OP_W'(OP_BNR));
   assign is_hlt = (opcode == OP_W'(OP_HLT));

   assign alu_op_instr = is_alu ? ALU_OP_W'({1'b0, is_imm}) : ALU_OP_W'(ALU_OP_DEFAULT);

   sisc_br_cond #(
      .OP_W   (OP_W),
      .MM_W   (MM_W),
      .STAT_W (STAT_W)
   ) u_br_cond (
      .opcode (bus.opcode),
      .mm     (bus.mm),
      .stat   (bus.stat),
      .taken  (br_taken)
   );

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state_q  <= ST_START1;
         to_cnt_q <= '0;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         to_cnt_q <= to_cnt_d;
         halted_q <= halted_d;
         fault_q  <= fault_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      to_cnt_d = to_cnt_q;
      halted_d = halted_q;
      fault_d  = fault_q;
      rf_we    = 1'b0;
      alu_op   = ALU_OP_W'(ALU_OP_DEFAULT);
      wb_sel   = 1'b0;
      ir_load  = 1'b0;
      pc_write = 1'b0;
      pc_sel   = 1'b0;
      br_sel   = 1'b0;
      dm_we    = 1'b0;
      swp_sel  = 1'b0;

      case (state_q)
         ST_START0: state_d = ST_START1;
         ST_START1: state_d = ST_FETCH;
         ST_FETCH: begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
            state_d  = ST_DECODE;
         end
         ST_DECODE: begin
            if (is_hlt) begin
               state_d  = ST_HALT;
               halted_d = 1'b1;
            end else begin
               pc_write = br_taken;
               pc_sel   = br_taken;
               br_sel   = br_taken && is_rel;
               state_d  = ST_EXECUTE;
            end
         end
         ST_EXECUTE: begin
            alu_op  = alu_op_instr;
            state_d = ST_MEM;
         end
         ST_MEM: begin
            // Ready is tested before the timeout so a late ready still completes.
            alu_op = alu_op_instr;
            if (!is_mem) begin
               state_d = ST_WRITEBACK;
            end else if (bus.mem_rdy) begin
               dm_we    = is_str || is_swp;
               to_cnt_d = '0;
               state_d  = ST_WRITEBACK;
            end else if (to_cnt_q == TO_W'(MEM_TIMEOUT)) begin
               to_cnt_d = '0;
               halted_d = 1'b1;
               fault_d  = 1'b1;
               state_d  = ST_HALT;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         ST_WRITEBACK: begin
            state_d = ST_FETCH;
            if (is_alu) begin
               rf_we = 1'b1;
            end else if (is_lod) begin
               rf_we  = 1'b1;
               wb_sel = 1'b1;
            end else if (is_swp) begin
               rf_we   = 1'b1;
               wb_sel  = 1'b1;
               state_d = ST_WB2;
            end
         end
         ST_WB2: begin
            rf_we   = 1'b1;
            swp_sel = 1'b1;
            state_d = ST_FETCH;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_START1;
      endcase
   end

   assign bus.rf_we    = rf_we;
   assign bus.alu_op   = alu_op;
   assign bus.wb_sel   = wb_sel;
   assign bus.ir_load  = ir_load;
   assign bus.pc_write = pc_write;
   assign bus.pc_sel   = pc_sel;
   assign bus.br_sel   = br_sel;
   assign bus.dm_we    = dm_we;
   assign bus.swp_sel  = swp_sel;
   assign bus.halted   = halted_q;
   assign bus.fault    = fault_q;

endmodule

// File: tb/tb_sisc_ctrl_fsm.sv
// Self-checking bench for sisc_ctrl_fsm: each instruction is expanded into its
// expected per-cycle control vectors from the instruction-level rules.
module tb_sisc_ctrl_fsm;

   localparam int MEM_TIMEOUT = 15;
   localparam logic O = 1'b0;
   localparam logic I = 1'b1;
   localparam logic [11:0] RESET_VEC = 12'b0_10_000000000;

   logic clk;
   logic rst_f;
   int   assert_count;
   int   fail_count;
   logic model_halted;
   logic model_fault;

   sisc_ctrl_fsm_if bus_if ();

   sisc_ctrl_fsm dut (
      .clk   (clk),
      .rst_f (rst_f),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Vector order: rf_we, alu_op[1:0], wb_sel, ir_load, pc_write, pc_sel, br_sel, dm_we, swp_sel, halted, fault
   function automatic logic [11:0] mk(input logic rf_we, input logic [1:0] alu,
                                      input logic wb_sel, input logic ir_load, input logic pc_write,
                                      input logic pc_sel, input logic br_sel, input logic dm_we,
                                      input logic swp_sel, input logic halted, input logic fault);
      return {rf_we, alu, wb_sel, ir_load, pc_write, pc_sel, br_sel, dm_we, swp_sel, halted, fault};
   endfunction

   function automatic logic [11:0] observed_vec();
      return {bus_if.rf_we, bus_if.alu_op, bus_if.wb_sel, bus_if.ir_load, bus_if.pc_write,
              bus_if.pc_sel, bus_if.br_sel, bus_if.dm_we, bus_if.swp_sel, bus_if.halted, bus_if.fault};
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic applyStimulus(input logic [3:0] op, input logic [3:0] mm,
                                input logic [3:0] stat, input logic rdy);
      bus_if.opcode  = op;
      bus_if.mm      = mm;
      bus_if.stat    = stat;
      bus_if.mem_rdy = rdy;
   endtask

   task automatic checkOutput(input string tag, input logic [11:0] expected);
      logic [11:0] observed;
      observed = observed_vec();
      assert_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   // Drive one cycle's inputs, check mid-cycle, then move just past the next rising edge.
   task automatic stepCheck(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] stat,
                            input logic rdy, input string tag, input logic [11:0] expected);
      applyStimulus(op, mm, stat, rdy);
      @(negedge clk);
      checkOutput(tag, expected);
      @(posedge clk);
      #1;
   endtask

   task automatic pulseReset(input string tag);
      #1 rst_f = 1'b0;
      bus_if.mem_rdy = 1'b1;
      #1 checkOutput({tag, "_async"}, RESET_VEC);
      @(posedge clk);
      #1 checkOutput({tag, "_held"}, RESET_VEC);
      @(negedge clk);
      #1 rst_f = 1'b1;
      @(posedge clk);
      #1;
      model_halted = 1'b0;
      model_fault  = 1'b0;
   endtask

   task automatic haltCycles(input int n, input string tag);
      for (int i = 0; i < n; i++)
         stepCheck(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   rnd_bit(), tag, mk(O, 2'b10, O, O, O, O, O, O, O, I, model_fault));
   endtask

   // Reference model: one instruction from FETCH; waits = not-ready MEM cycles before ready.
   task automatic runInstr(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] stat,
                           input int waits);
      logic       hit, taken, rel, is_mem, writes_mem;
      logic [1:0] alu_exp;
      hit = ((stat & mm) != 4'd0);
      rel = (op == 4'd5) || (op == 4'd7);
      if ((op == 4'd4) || (op == 4'd5))      taken = hit;
      else if ((op == 4'd6) || (op == 4'd7)) taken = !hit;
      else                                   taken = 1'b0;
      is_mem     = (op >= 4'd1) && (op <= 4'd3);
      writes_mem = (op == 4'd2) || (op == 4'd3);
      alu_exp    = (op == 4'd8) ? {1'b0, (mm == 4'd8)} : 2'b10;

      stepCheck(op, mm, stat, rnd_bit(), "fetch", mk(O, 2'b10, O, I, I, O, O, O, O, O, O));
      if (op == 4'd15) begin
         stepCheck(op, mm, stat, rnd_bit(), "decode_hlt", RESET_VEC);
         model_halted = 1'b1;
         return;
      end
      stepCheck(op, mm, stat, rnd_bit(), "decode",
                mk(O, 2'b10, O, O, taken, taken, taken && rel, O, O, O, O));
      stepCheck(op, mm, stat, rnd_bit(), "execute", mk(O, alu_exp, O, O, O, O, O, O, O, O, O));
      if (is_mem) begin
         for (int w = 0; w <= MEM_TIMEOUT; w++) begin
            if (w == waits) begin
               stepCheck(op, mm, stat, 1'b1, "mem_ready",
                         mk(O, alu_exp, O, O, O, O, O, writes_mem, O, O, O));
               break;
            end
            stepCheck(op, mm, stat, 1'b0, "mem_wait", mk(O, alu_exp, O, O, O, O, O, O, O, O, O));
         end
         if (waits > MEM_TIMEOUT) begin
            model_halted = 1'b1;
            model_fault  = 1'b1;
            return;
         end
      end else begin
         stepCheck(op, mm, stat, rnd_bit(), "mem_pass", mk(O, alu_exp, O, O, O, O, O, O, O, O, O));
      end
      case (op)
         4'd8: stepCheck(op, mm, stat, rnd_bit(), "wb_alu", mk(I, 2'b10, O, O, O, O, O, O, O, O, O));
         4'd1: stepCheck(op, mm, stat, rnd_bit(), "wb_lod", mk(I, 2'b10, I, O, O, O, O, O, O, O, O));
         4'd3: begin
            stepCheck(op, mm, stat, rnd_bit(), "wb_swp", mk(I, 2'b10, I, O, O, O, O, O, O, O, O));
            stepCheck(op, mm, stat, rnd_bit(), "wb2_swp", mk(I, 2'b10, O, O, O, O, O, O, I, O, O));
         end
         default: stepCheck(op, mm, stat, rnd_bit(), "wb_none", RESET_VEC);
      endcase
   endtask

   initial begin
      logic [3:0] r_op, r_mm, r_stat;
      assert_count = 0;
      fail_count   = 0;
      model_halted = 1'b0;
      model_fault  = 1'b0;
      rst_f        = 1'b0;
      applyStimulus(4'd0, 4'd0, 4'd0, 1'b0);

      repeat (2) @(posedge clk);
      #1 checkOutput("reset_state", RESET_VEC);
      @(negedge clk);
      #1 rst_f = 1'b1;
      @(posedge clk);
      #1;

      runInstr(4'd8, 4'd0, 4'd5, 0);

      // ADD immediate aborted by reset during EXECUTE
      stepCheck(4'd8, 4'd8, 4'd0, 1'b0, "addi_abort_fetch", mk(O, 2'b10, O, I, I, O, O, O, O, O, O));
      stepCheck(4'd8, 4'd8, 4'd0, 1'b0, "addi_abort_decode", RESET_VEC);
      applyStimulus(4'd8, 4'd8, 4'd0, 1'b0);
      @(negedge clk);
      checkOutput("addi_abort_exec", mk(O, 2'b01, O, O, O, O, O, O, O, O, O));
      pulseReset("addi_abort");

      runInstr(4'd8, 4'd8, 4'd3, 0);
      runInstr(4'd5, 4'b0010, 4'b0010, 0);
      runInstr(4'd6, 4'b0010, 4'b0010, 0);
      runInstr(4'd7, 4'b0001, 4'b0010, 0);
      runInstr(4'd4, 4'b0001, 4'b0010, 0);
      runInstr(4'd2, 4'd6, 4'd1, 3);
      runInstr(4'd1, 4'd2, 4'd9, MEM_TIMEOUT);
      runInstr(4'd3, 4'd0, 4'd0, 1);
      runInstr(4'd12, 4'd8, 4'd15, 0);

      // STR aborted by reset while waiting on memory
      stepCheck(4'd2, 4'd0, 4'd0, 1'b0, "str_abort_fetch", mk(O, 2'b10, O, I, I, O, O, O, O, O, O));
      stepCheck(4'd2, 4'd0, 4'd0, 1'b0, "str_abort_decode", RESET_VEC);
      stepCheck(4'd2, 4'd0, 4'd0, 1'b0, "str_abort_exec", RESET_VEC);
      stepCheck(4'd2, 4'd0, 4'd0, 1'b0, "str_abort_wait", RESET_VEC);
      applyStimulus(4'd2, 4'd0, 4'd0, 1'b0);
      @(negedge clk);
      checkOutput("str_abort_wait2", RESET_VEC);
      pulseReset("str_abort");
      runInstr(4'd1, 4'd0, 4'd0, MEM_TIMEOUT);

      for (int n = 0; n < 40; n++) begin
         r_op   = 4'($urandom_range(0, 14));
         r_mm   = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
         r_stat = 4'($urandom_range(0, 15));
         runInstr(r_op, r_mm, r_stat, int'($urandom_range(0, 5)));
      end

      runInstr(4'd1, 4'd0, 4'd0, 99);
      haltCycles(20, "timeout_halt");
      @(negedge clk);
      pulseReset("fault_clear");

      runInstr(4'd0, 4'd0, 4'd0, 0);
      runInstr(4'd15, 4'd0, 4'd0, 0);
      haltCycles(20, "hlt_halt");
      @(negedge clk);
      pulseReset("hlt_clear");
      runInstr(4'd3, 4'd1, 4'd1, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
